// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with combinational read ports, one write-back port,
// optional write-to-read bypass and a per-register pending-write scoreboard.
module regfile_scoreboard #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned RD_PORTS = 2,
    parameter int unsigned CNT_W    = 2,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [RD_PORTS-1:0]          rd_en,
    input  logic [RD_PORTS*ADDR_W-1:0]   rd_addr,
    output logic [RD_PORTS*DATA_W-1:0]   rd_data,
    output logic [RD_PORTS-1:0]          rd_hazard,
    output logic                         hazard_any,
    input  logic                         issue_en,
    input  logic [ADDR_W-1:0]            issue_dest,
    output logic                         issue_ready,
    input  logic                         wb_en,
    input  logic [ADDR_W-1:0]            wb_addr,
    input  logic [DATA_W-1:0]            wb_data,
    input  logic                         flush
);

    localparam int unsigned      NUM_REGS = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic             BYP      = (BYPASS != 0);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [CNT_W-1:0]    cnt  [NUM_REGS];
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;

    assign issue_ready = (cnt[issue_dest] != CNT_MAX);

    always_comb begin
        inc = '0;
        dec = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            inc[r] = issue_en && issue_ready && (issue_dest == ADDR_W'(r));
            dec[r] = wb_en && (wb_addr == ADDR_W'(r)) && (cnt[r] != '0);
        end
    end

    // Flush only clears the scoreboard; the write-back data still lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
        end else begin
            if (wb_en)
                regs[wb_addr] <= wb_data;
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (flush)
                    cnt[r] <= '0;
                else if (inc[r] && !dec[r])
                    cnt[r] <= cnt[r] + CNT_W'(1);
                else if (dec[r] && !inc[r])
                    cnt[r] <= cnt[r] - CNT_W'(1);
            end
        end
    end

    for (genvar i = 0; i < RD_PORTS; i++) begin : g_port
        logic [ADDR_W-1:0] addr;
        logic [CNT_W-1:0]  pend;
        logic              hit;

        assign addr = rd_addr[i*ADDR_W +: ADDR_W];
        assign pend = cnt[addr];
        assign hit  = BYP && wb_en && (wb_addr == addr);
        assign rd_data[i*DATA_W +: DATA_W] = hit ? wb_data : regs[addr];
        // The last outstanding write completing now is forwarded, so no stall.
        assign rd_hazard[i] = rd_en[i] && (pend != '0) && !(hit && (pend == CNT_W'(1)));
    end

    assign hazard_any = |rd_hazard;

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised register file for the decode stage, with a built-in scoreboard for in-flight writes.
- Has RD_PORTS combinational read ports, one write-back port and optional write-to-read bypass.
- Keeps a per-register pending-write counter and raises a per-port hazard when a read source has an outstanding write.
- Replaces the separate register file plus external hazard unit in the ID stage. Supports wider datapaths, more read ports and multiple outstanding writes to the same register.

Parameters:
- DATA_W, 32: register width in bits.
- ADDR_W, 4: register address width; NUM_REGS = 2**ADDR_W.
- RD_PORTS, 2: number of read ports.
- CNT_W, 2: width of each pending-write counter; max outstanding writes per register = 2**CNT_W-1.
- BYPASS, 1: 1 = same-cycle write-back data forwarded to reads; 0 = no forwarding.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: asynchronous active-low reset.
- rd_en, input, RD_PORTS: per-port read-valid, used only for hazard qualification.
- rd_addr, input, RD_PORTS*ADDR_W: packed read addresses; port i occupies [i*ADDR_W +: ADDR_W].
- rd_data, output, RD_PORTS*DATA_W: packed read data; port i occupies [i*DATA_W +: DATA_W].
- rd_hazard, output, RD_PORTS: per-port pending-write hazard.
- hazard_any, output, 1: OR of rd_hazard.
- issue_en, input, 1: an instruction that will write issue_dest leaves decode this cycle.
- issue_dest, input, ADDR_W: destination register of the issuing instruction.
- issue_ready, output, 1: high when the counter of issue_dest is below max.
- wb_en, input, 1: write-back valid.
- wb_addr, input, ADDR_W: write-back destination.
- wb_data, input, DATA_W: write-back value.
- flush, input, 1: synchronous clear of all pending counters (branch flush).

Behaviour:
- Reset, with rst low and asynchronous:
  - all registers are 0;
  - all counters are 0;
  - rd_hazard = 0, hazard_any = 0, issue_ready = 1.
  - Reset mid-operation discards any pending writes and counts immediately.
- Write: at the rising edge with wb_en=1, reg[wb_addr] <= wb_data.
- Read is combinational with zero latency:
  - rd_data[i] = reg[rd_addr[i]];
  - if BYPASS=1, wb_en=1 and wb_addr==rd_addr[i], rd_data[i] = wb_data instead.
- Counter update per register r, each rising edge:
  - inc = issue_en & issue_ready & (issue_dest==r);
  - dec = wb_en & (wb_addr==r) & (cnt[r]!=0);
  - inc & dec: no change;
  - inc only: +1;
  - dec only: -1;
  - neither: hold.
- Underflow: a write-back to a register whose counter is 0 still writes data but leaves the counter at 0. This covers stale write-backs after a flush.
- Saturation: issue_ready = (cnt[issue_dest] != 2**CNT_W-1). An issue_en while issue_ready=0 is ignored by the scoreboard; the upstream stall is the issuer's responsibility.
- Flush: at the rising edge with flush=1, all counters are set to 0 and any issue or write-back counter change in that cycle is discarded. The data write from wb_en is still performed.
- Hazard, combinational:
  - rd_hazard[i] = rd_en[i] & (cnt[rd_addr[i]]!=0) & ~resolve[i];
  - resolve[i] = BYPASS & wb_en & (wb_addr==rd_addr[i]) & (cnt[rd_addr[i]]==1);
  - with BYPASS=0, resolve is 0, so the hazard clears in the cycle after write-back.
- Multiple ports reading the same address get identical data and hazard.
- issue_dest equal to a read address in the same cycle: the hazard reflects the pre-issue count (no self-hazard).
- Address ranges are full; no register is hard-wired.

Test Plan:
- Reset: drive rst=0 mid-run with cnt[3]=2 and reg[3]=0x55 -> immediately rd_data=0, rd_hazard=0, issue_ready=1. After release, reg[3] reads 0.
- Write/read: wb_en, wb_addr=5, wb_data=0xDEADBEEF; next cycle rd_addr[0]=5 and rd_addr[1]=5 -> both ports read 0xDEADBEEF, rd_hazard=0.
- Bypass, BYPASS=1:
  - issue R2 (cnt=1); one cycle later rd_en[0] on R2 -> rd_hazard[0]=1;
  - in the write-back cycle with wb_data=0x1234 -> rd_data[0]=0x1234, rd_hazard[0]=0 in the same cycle.
  - With BYPASS=0, the hazard drops one cycle later.
- WAW: issue R7 twice (cnt=2), then one write-back -> hazard stays 1; second write-back -> hazard 0. Simultaneous issue and write-back of R7 leaves cnt unchanged.
- Saturation, CNT_W=2: issue R1 three times -> issue_ready=0; a 4th issue_en is ignored; after one write-back, issue_ready=1 and cnt=2.
- Flush: cnt[4]=2, assert flush -> cnt=0, hazard 0; later stale write-back to R4 with 0xAB -> reg[4]=0xAB, cnt stays 0.
